// File: rtl/psum_collector_if.sv
// Stream bundle between the bottom PE row, the collector and the output buffer.
// The slave side is the collector; the master side is its environment.
interface psum_collector_if #(
    parameter int WIDTH    = 16,
    parameter int ACC_BITS = 4
);
    localparam int A_WIDTH = 2 * WIDTH + 1;
    localparam int OW      = A_WIDTH + ACC_BITS;

    logic               ipsum_vld;
    logic [A_WIDTH-1:0] ipsum;
    logic               o_vld;
    logic               o_rdy;
    logic [OW-1:0]      o_data;

    modport slave (
        input  ipsum_vld,
        input  ipsum,
        input  o_rdy,
        output o_vld,
        output o_data
    );

    modport master (
        output ipsum_vld,
        output ipsum,
        output o_rdy,
        input  o_vld,
        input  o_data
    );
endinterface

// File: rtl/psum_collector.sv
// Column partial-sum collector: reduces acc_len valid samples into one result
// and queues results in a show-ahead FIFO drained over valid/ready.
module psum_collector #(
    parameter int WIDTH    = 16,
    parameter int ACC_BITS = 4,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [7:0]               acc_len,
    psum_collector_if.slave          bus,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     overflow,
    output logic                     busy
);
    localparam int A_WIDTH = 2 * WIDTH + 1;
    localparam int OW      = A_WIDTH + ACC_BITS;
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] acc, acc_nxt, sum;
    logic [7:0]    cnt, cnt_nxt;
    logic [7:0]    len_reg, len_nxt, len_eff;
    logic          push;

    logic [OW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
    logic [OW-1:0] head, head_nxt;
    logic          pop, full, wr_en;

    // Accumulator next-state. The group length is latched on the first sample,
    // so acc_len may change freely while a group is in flight.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_reg;
        push      = 1'b0;
        len_eff   = len_reg;
        sum       = acc + OW'(bus.ipsum);
        if (state == IDLE) begin
            len_eff = (acc_len == 8'd0) ? 8'd1 : acc_len;
            sum     = OW'(bus.ipsum);
        end
        if (bus.ipsum_vld) begin
            len_nxt = len_eff;
            if (cnt == len_eff - 8'd1) begin
                push      = 1'b1;
                cnt_nxt   = 8'd0;
                state_nxt = IDLE;
            end else begin
                acc_nxt   = sum;
                cnt_nxt   = cnt + 8'd1;
                state_nxt = ACCUM;
            end
        end
    end

    assign pop        = bus.o_vld && bus.o_rdy;
    assign full       = (fifo_cnt == CW'(DEPTH));
    assign wr_en      = push && (!full || pop);
    assign rd_ptr_inc = rd_ptr + PW'(1);

    // Next head register value: the entry behind the popped one, or the
    // fresh result when it lands in an empty (or emptying) FIFO.
    always_comb begin
        head_nxt = head;
        if (pop) begin
            if (fifo_cnt == CW'(1)) begin
                if (wr_en) head_nxt = sum;
            end else begin
                head_nxt = mem[rd_ptr_inc];
            end
        end else if (fifo_cnt == CW'(0) && wr_en) begin
            head_nxt = sum;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst || clr) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= 8'd0;
            len_reg  <= 8'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            overflow <= 1'b0;
            head     <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            len_reg <= len_nxt;
            head    <= head_nxt;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr_inc;
            if (wr_en && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!wr_en && pop) fifo_cnt <= fifo_cnt - CW'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= sum;
    end

    assign bus.o_vld  = (fifo_cnt != CW'(0));
    assign bus.o_data = head;
    assign busy       = (cnt != 8'd0) || (fifo_cnt != CW'(0));

endmodule

// File: tb/tb_psum_collector.sv
// Self-checking bench for psum_collector: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_psum_collector;
    localparam int WIDTH    = 16;
    localparam int ACC_BITS = 4;
    localparam int DEPTH    = 8;
    localparam int A_WIDTH  = 2 * WIDTH + 1;
    localparam int OW       = A_WIDTH + ACC_BITS;

    logic             clk;
    logic             rst;
    logic             clr;
    logic [7:0]       acc_len;
    logic [3:0]       fifo_cnt;
    logic             overflow;
    logic             busy;

    psum_collector_if #(.WIDTH(WIDTH), .ACC_BITS(ACC_BITS)) bus ();

    psum_collector #(.WIDTH(WIDTH), .ACC_BITS(ACC_BITS), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .acc_len  (acc_len),
        .bus      (bus),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: results as a queue, group progress as a sample counter.
    logic [OW-1:0] ref_q[$];
    logic [OW-1:0] ref_acc;
    int            ref_cnt;
    int            ref_len;
    bit            ref_ovf;

    localparam logic [A_WIDTH-1:0] MAX_IN = {A_WIDTH{1'b1}};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [A_WIDTH-1:0] d, input bit r, input bit c);
        bit do_pop;
        bit was_full;
        if (!rst || c) begin
            ref_q.delete();
            ref_acc = '0;
            ref_cnt = 0;
            ref_len = 0;
            ref_ovf = 1'b0;
        end else begin
            do_pop   = (ref_q.size() != 0) && r;
            was_full = (ref_q.size() == DEPTH);
            if (do_pop) void'(ref_q.pop_front());
            if (v) begin
                if (ref_cnt == 0) begin
                    ref_len = (acc_len == 0) ? 1 : int'(acc_len);
                    ref_acc = '0;
                end
                ref_acc = ref_acc + OW'(d);
                ref_cnt++;
                if (ref_cnt == ref_len) begin
                    ref_cnt = 0;
                    if (was_full && !do_pop) ref_ovf = 1'b1;
                    else ref_q.push_back(ref_acc);
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input logic [A_WIDTH-1:0] d, input bit r, input bit c);
        bus.ipsum_vld = v;
        bus.ipsum     = d;
        bus.o_rdy     = r;
        clr           = c;
        @(posedge clk);
        model_edge(v, d, r, c);
        #1;
        check("o_vld", 64'(bus.o_vld), 64'(ref_q.size() != 0));
        check("fifo_cnt", 64'(fifo_cnt), 64'(ref_q.size()));
        check("overflow", 64'(overflow), 64'(ref_ovf));
        check("busy", 64'(busy), 64'((ref_cnt != 0) || (ref_q.size() != 0)));
        if (ref_q.size() != 0) check("o_data", 64'(bus.o_data), 64'(ref_q[0]));
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r, 1'b0);
    endtask

    logic [63:0] rnd;
    logic [A_WIDTH-1:0] din;

    initial begin
        rst           = 1'b0;
        clr           = 1'b0;
        acc_len       = 8'd1;
        bus.ipsum_vld = 1'b0;
        bus.ipsum     = '0;
        bus.o_rdy     = 1'b0;
        ref_acc = '0; ref_cnt = 0; ref_len = 0; ref_ovf = 1'b0;

        idle(2, 1'b0);
        check("reset_o_data", 64'(bus.o_data), 64'd0);
        rst = 1'b1;
        idle(1, 1'b0);

        // acc_len=1, back-to-back samples, each result one cycle later
        acc_len = 8'd1;
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, A_WIDTH'(10 * i), 1'b1, 1'b0);
            check("t1_data", 64'(bus.o_data), 64'(10 * i));
        end
        idle(2, 1'b1);

        // acc_len=4 with an idle gap inside the group
        acc_len = 8'd4;
        step(1'b1, 33'd1, 1'b1, 1'b0);
        step(1'b1, 33'd2, 1'b1, 1'b0);
        idle(1, 1'b1);
        step(1'b1, 33'd3, 1'b1, 1'b0);
        step(1'b1, 33'd4, 1'b1, 1'b0);
        check("t2_sum", 64'(bus.o_data), 64'd10);
        idle(1, 1'b1);
        check("t2_busy", 64'(busy), 64'd0);

        // overflow with o_rdy low, then drain in order
        acc_len = 8'd1;
        for (int i = 1; i <= 9; i++) step(1'b1, A_WIDTH'(i), 1'b0, 1'b0);
        check("t3_cnt", 64'(fifo_cnt), 64'd8);
        check("t3_ovf", 64'(overflow), 64'd1);
        for (int i = 1; i <= 8; i++) begin
            check("t3_drain", 64'(bus.o_data), 64'(i));
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("t3_empty", 64'(bus.o_vld), 64'd0);

        // full FIFO: push and pop together
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step(1'b1, A_WIDTH'(100 + i), 1'b0, 1'b0);
        step(1'b1, 33'd999, 1'b1, 1'b0);
        check("t4_cnt", 64'(fifo_cnt), 64'd8);
        check("t4_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t4_last", 64'(bus.o_data), 64'd999);
        idle(2, 1'b1);

        // wide operands: exact and wrapped results
        acc_len = 8'd16;
        for (int i = 0; i < 16; i++) step(1'b1, MAX_IN, 1'b1, 1'b0);
        check("t5_16", 64'(bus.o_data), 64'h1F_FFFF_FFF0);
        acc_len = 8'd17;
        for (int i = 0; i < 17; i++) step(1'b1, MAX_IN, 1'b1, 1'b0);
        check("t5_17", 64'(bus.o_data), 64'h1_FFFF_FFEF);
        idle(2, 1'b1);

        // flush mid-group by clr, then by rst
        acc_len = 8'd4;
        for (int pass = 0; pass < 2; pass++) begin
            step(1'b1, 33'd7, 1'b1, 1'b0);
            step(1'b1, 33'd7, 1'b1, 1'b0);
            if (pass == 0) begin
                step(1'b1, 33'd7, 1'b1, 1'b1);
            end else begin
                rst = 1'b0;
                step(1'b1, 33'd7, 1'b1, 1'b0);
                rst = 1'b1;
            end
            check("t6_busy", 64'(busy), 64'd0);
            for (int i = 0; i < 4; i++) step(1'b1, 33'd1, 1'b1, 1'b0);
            check("t6_sum", 64'(bus.o_data), 64'd4);
            idle(1, 1'b1);
        end

        // group length latched at the first sample
        acc_len = 8'd4;
        step(1'b1, 33'd5, 1'b1, 1'b0);
        acc_len = 8'd2;
        step(1'b1, 33'd5, 1'b1, 1'b0);
        check("t6_len_hold", 64'(bus.o_vld), 64'd0);
        step(1'b1, 33'd5, 1'b1, 1'b0);
        step(1'b1, 33'd5, 1'b1, 1'b0);
        check("t6_len_sum", 64'(bus.o_data), 64'd20);
        idle(2, 1'b1);

        // random traffic with varying backpressure, lengths, flushes and resets
        for (int i = 0; i < 3000; i++) begin
            bit v, r, c;
            if ($urandom_range(0, 49) == 0) acc_len = 8'($urandom_range(0, 6));
            rnd = {$urandom(), $urandom()};
            din = ($urandom_range(0, 3) == 0) ? MAX_IN : rnd[A_WIDTH-1:0];
            v = ($urandom_range(0, 2) != 0);
            r = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 299) == 0);
            rst = ($urandom_range(0, 499) != 0);
            step(v, din, r, c);
        end
        rst = 1'b1;
        idle(DEPTH + 2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
